// File: rtl/gmsk_pkg.sv
// Shared definitions for the GMSK burst path: FSM states, GSM burst
// constants and the training sequence table.
// Optional build macro: GMSK_BURST_TSC_EN (adds the TSC/PAY2 states).
package gmsk_pkg;

    localparam int unsigned GSM_TAIL      = 3;
    localparam int unsigned GSM_DATA_HALF = 58;
    localparam int unsigned GSM_TSC_LEN   = 26;
    localparam int unsigned GSM_GUARD     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_LEAD,
        ST_PAY,
        ST_TRAIL,
        ST_GUARD
`ifdef GMSK_BURST_TSC_EN
        , ST_TSC
        , ST_PAY2
`endif
    } burst_state_t;

    // GSM training sequences 0..7, MSB is the first symbol sent.
    localparam logic [GSM_TSC_LEN-1:0] GSM_TSC_TABLE [8] = '{
        26'b00100101110000100010010111,
        26'b00101101110111100010110111,
        26'b01000011101110100100001110,
        26'b01000111101101000100011110,
        26'b00011010111001000001101011,
        26'b01001110101100000100111010,
        26'b10100111110110001010011111,
        26'b11101111000100101110111100
    };

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gmsk_sample_divider.sv
// Free-running clock divider producing a one-cycle sample strobe every
// DIV cycles. Never gated; shared between TX and RX sample timing.
module gmsk_sample_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    output logic strobe_o
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("gmsk_sample_divider: DIV must be at least 2");
    end

    logic [CW-1:0] count;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign strobe_o = (count == LAST);

endmodule

// File: rtl/gmsk_burst_sequencer.sv
// Sequences one GSM normal burst (lead tail, payload, trailing tail, guard)
// into gmsk_modulate, one symbol per modulator symbol period.
// Optional build macro: GMSK_BURST_TSC_EN (mid-burst training sequence
// from the internal ROM, selected by tsc_sel_i).
module gmsk_burst_sequencer #(
    parameter int unsigned SAMPLE_DIV   = 4,
    parameter int unsigned TAIL_BITS    = 3,
    parameter int unsigned PAYLOAD_BITS = 142,
    parameter int unsigned GUARD_BITS   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    output logic       bit_ready_o,
    input  logic       mod_symbol_strobe_i,
    output logic       sample_strobe_o,
    output logic       symbol_o,
    output logic       busy_o,
    output logic       tx_active_o,
    output logic       underrun_o,
    output logic       done_o
`ifdef GMSK_BURST_TSC_EN
    ,
    input  logic [2:0] tsc_sel_i
`endif
);

    import gmsk_pkg::*;

    localparam int unsigned MAX_LEN = max3(TAIL_BITS, PAYLOAD_BITS, GUARD_BITS);
    localparam int unsigned CW      = $clog2(MAX_LEN) + 1;

`ifdef GMSK_BURST_TSC_EN
    localparam int unsigned PAY1_LEN = GSM_DATA_HALF;
    if (PAYLOAD_BITS != 2 * GSM_DATA_HALF + GSM_TSC_LEN) begin : g_payload_check
        $error("gmsk_burst_sequencer: PAYLOAD_BITS must be 142 with the TSC enabled");
    end
`else
    localparam int unsigned PAY1_LEN = PAYLOAD_BITS;
`endif

    burst_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, phase_last;
    logic          symbol_q, symbol_d;
    logic          busy_q, busy_d;
    logic          tx_active_q, tx_active_d;
    logic          underrun_q, underrun_d;
    logic          done_q, done_d;
    logic          mod_strobe_q;
    logic          sym_tick, phase_end, in_phase, in_pay, bit_ready;
`ifdef GMSK_BURST_TSC_EN
    logic [2:0]             tsc_sel_q, tsc_sel_d;
    logic [GSM_TSC_LEN-1:0] tsc_word;
    assign tsc_word = GSM_TSC_TABLE[tsc_sel_q];
`endif

    gmsk_sample_divider #(.DIV(SAMPLE_DIV)) u_divider (
        .clock    (clock),
        .reset_n  (reset_n),
        .strobe_o (sample_strobe_o)
    );

    assign sym_tick  = mod_symbol_strobe_i & ~mod_strobe_q;
    assign phase_end = (cnt_q == phase_last);
    assign in_phase  = (state_q != ST_IDLE) && (state_q != ST_PEND);
`ifdef GMSK_BURST_TSC_EN
    assign in_pay    = (state_q == ST_PAY) || (state_q == ST_PAY2);
`else
    assign in_pay    = (state_q == ST_PAY);
`endif

    // Last counter value of the phase currently being presented.
    always_comb begin
        phase_last = CW'(GUARD_BITS - 1);
        case (state_q)
            ST_LEAD, ST_TRAIL: phase_last = CW'(TAIL_BITS - 1);
            ST_PAY:            phase_last = CW'(PAY1_LEN - 1);
`ifdef GMSK_BURST_TSC_EN
            ST_TSC:            phase_last = CW'(GSM_TSC_LEN - 1);
            ST_PAY2:           phase_last = CW'(GSM_DATA_HALF - 1);
`endif
            default:           phase_last = CW'(GUARD_BITS - 1);
        endcase
    end

    // Next-state, symbol selection and flag updates; everything advances on sym_tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        symbol_d    = symbol_q;
        busy_d      = busy_q;
        tx_active_d = tx_active_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        bit_ready   = 1'b0;
`ifdef GMSK_BURST_TSC_EN
        tsc_sel_d   = tsc_sel_q;
`endif
        if (sym_tick && in_phase) begin
            cnt_d    = phase_end ? '0 : cnt_q + 1'b1;
            symbol_d = 1'b0;
        end
        if (sym_tick && in_pay) begin
            if (bit_valid_i) begin
                bit_ready = 1'b1;
                symbol_d  = bit_i;
            end else begin
                underrun_d = 1'b1;
            end
        end
        case (state_q)
            ST_IDLE: begin
                // done_q high means the previous burst ended on this very edge
                if (start_i && !done_q) begin
                    state_d    = ST_PEND;
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
`ifdef GMSK_BURST_TSC_EN
                    tsc_sel_d  = tsc_sel_i;
`endif
                end
            end
            ST_PEND: begin
                if (sym_tick) begin
                    state_d     = ST_LEAD;
                    cnt_d       = '0;
                    tx_active_d = 1'b1;
                end
            end
            ST_LEAD: begin
                if (sym_tick && phase_end) state_d = ST_PAY;
            end
            ST_PAY: begin
`ifdef GMSK_BURST_TSC_EN
                if (sym_tick && phase_end) state_d = ST_TSC;
`else
                if (sym_tick && phase_end) state_d = ST_TRAIL;
`endif
            end
`ifdef GMSK_BURST_TSC_EN
            ST_TSC: begin
                if (sym_tick) begin
                    symbol_d = tsc_word[5'(GSM_TSC_LEN - 1) - cnt_q[4:0]];
                    if (phase_end) state_d = ST_PAY2;
                end
            end
            ST_PAY2: begin
                if (sym_tick && phase_end) state_d = ST_TRAIL;
            end
`endif
            ST_TRAIL: begin
                if (sym_tick && phase_end) begin
                    state_d     = ST_GUARD;
                    tx_active_d = 1'b0;
                end
            end
            ST_GUARD: begin
                if (sym_tick && phase_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset returns to IDLE with all flags low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            symbol_q     <= 1'b0;
            busy_q       <= 1'b0;
            tx_active_q  <= 1'b0;
            underrun_q   <= 1'b0;
            done_q       <= 1'b0;
            mod_strobe_q <= 1'b0;
`ifdef GMSK_BURST_TSC_EN
            tsc_sel_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            symbol_q     <= symbol_d;
            busy_q       <= busy_d;
            tx_active_q  <= tx_active_d;
            underrun_q   <= underrun_d;
            done_q       <= done_d;
            mod_strobe_q <= mod_symbol_strobe_i;
`ifdef GMSK_BURST_TSC_EN
            tsc_sel_q    <= tsc_sel_d;
`endif
        end
    end

    assign bit_ready_o = bit_ready;
    assign symbol_o    = symbol_q;
    assign busy_o      = busy_q;
    assign tx_active_o = tx_active_q;
    assign underrun_o  = underrun_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Testbench for gmsk_burst_sequencer. Build with GMSK_BURST_TSC_EN to
// exercise the training-sequence variant.
module tb_gmsk_burst_sequencer;

    localparam int unsigned SAMPLE_DIV = 4;
    localparam int TAIL  = 3;
    localparam int PAY   = 142;
    localparam int GUARD = 8;
    localparam int NSYM  = TAIL + PAY + TAIL + GUARD;
    localparam int SYM_PERIOD = 16;
`ifdef GMSK_BURST_TSC_EN
    localparam int FULL_READY = 116;
`else
    localparam int FULL_READY = 142;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start_i = 1'b0;
    logic bit_i = 1'b0;
    logic bit_valid_i = 1'b0;
    logic mod_symbol_strobe_i = 1'b0;
    logic bit_ready_o, sample_strobe_o, symbol_o, busy_o, tx_active_o, underrun_o, done_o;
`ifdef GMSK_BURST_TSC_EN
    logic [2:0]  tsc_sel_i = 3'd0;
    logic [25:0] tsc0_v = 26'b00100101110000100010010111;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mod_ph = 0;

    bit   exp_q[$];
    logic obs_q[$];
    int   n_ready, n_done, done_at, exp_ready;
    logic und_start, busy_start, txa_pay, busy_end, txa_end, und_end;

    gmsk_burst_sequencer #(
        .SAMPLE_DIV   (SAMPLE_DIV),
        .TAIL_BITS    (TAIL),
        .PAYLOAD_BITS (PAY),
        .GUARD_BITS   (GUARD)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start_i             (start_i),
        .bit_i               (bit_i),
        .bit_valid_i         (bit_valid_i),
        .bit_ready_o         (bit_ready_o),
        .mod_symbol_strobe_i (mod_symbol_strobe_i),
        .sample_strobe_o     (sample_strobe_o),
        .symbol_o            (symbol_o),
        .busy_o              (busy_o),
        .tx_active_o         (tx_active_o),
        .underrun_o          (underrun_o),
        .done_o              (done_o)
`ifdef GMSK_BURST_TSC_EN
        ,
        .tsc_sel_i           (tsc_sel_i)
`endif
    );

    initial forever #5 clock = ~clock;

    // Modulator stand-in: symbol strobe high for SAMPLE_DIV cycles every 16 cycles.
    initial forever begin
        @(posedge clock);
        #1;
        mod_ph = (mod_ph + 1) % SYM_PERIOD;
        mod_symbol_strobe_i = (mod_ph < int'(SAMPLE_DIV));
    end

    function automatic bit is_src(input int s);
`ifdef GMSK_BURST_TSC_EN
        return (s >= 3 && s < 61) || (s >= 87 && s < 145);
`else
        return (s >= 3 && s < 145);
`endif
    endfunction

    function automatic bit is_tsc(input int s);
`ifdef GMSK_BURST_TSC_EN
        return (s >= 61 && s < 87);
`else
        return (s < 0);
`endif
    endfunction

    // Drives one burst and records DUT observations; expected symbols are
    // pushed as each symbol tick is driven. Source bits alternate 1,0,...
    // and only advance when consumed; positions drop_lo..drop_hi are invalid.
    task automatic run_burst(input int drop_lo, input int drop_hi, input int restart_tick,
                             input int reset_sym);
        int tick_cnt = 0;
        int src_idx  = 0;
        int s;
        bit e;
        n_ready = 0; n_done = 0; done_at = -1; exp_ready = 0;
        exp_q.delete(); obs_q.delete();
        @(negedge clock); start_i = 1'b1;
        @(negedge clock); start_i = 1'b0;
        und_start = underrun_o; busy_start = busy_o;
        for (int c = 0; c < 200 * SYM_PERIOD; c++) begin
            if (c > 0) @(negedge clock);
            start_i = (restart_tick >= 0 && tick_cnt == restart_tick && mod_ph == 6);
            if (mod_ph == 0) begin
                s = tick_cnt - 1;
                bit_i = 1'b1; bit_valid_i = 1'b1; e = 1'b0;
                if (s >= 0 && is_src(s)) begin
                    bit_i = ~src_idx[0];
                    if (s >= drop_lo && s <= drop_hi) begin
                        bit_valid_i = 1'b0;
                    end else begin
                        e = bit_i;
                        exp_ready++;
                        src_idx++;
                    end
                end else if (s >= 0 && is_tsc(s)) begin
`ifdef GMSK_BURST_TSC_EN
                    e = tsc0_v[25 - (s - 61)];
`endif
                end
                if (s >= 0 && s < NSYM) exp_q.push_back(e);
                tick_cnt++;
            end
            #1;
            if (bit_ready_o === 1'b1) n_ready++;
            if (mod_ph == 1 && tick_cnt >= 2 && tick_cnt - 2 < NSYM) obs_q.push_back(symbol_o);
            if (mod_ph == 1 && tick_cnt - 2 == 70) txa_pay = tx_active_o;
            if (done_o === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = tick_cnt - 1;
            end
            if (reset_sym >= 0 && mod_ph == 1 && tick_cnt - 2 == reset_sym) begin
                reset_n = 1'b0;
                return;
            end
            if (done_at >= 0 && mod_ph == 8) break;
        end
        busy_end = busy_o; txa_end = tx_active_o; und_end = underrun_o;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if ({bit_ready_o, sample_strobe_o, symbol_o, busy_o, tx_active_o, underrun_o, done_o} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {bit_ready_o, sample_strobe_o, symbol_o, busy_o, tx_active_o, underrun_o, done_o});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            n_cmp++;
            if (sample_strobe_o !== ((i % 4) == 3)) begin
                n_bad++;
                $display("FAIL sample_strobe cycle=%0d got=%b exp=%b", i, sample_strobe_o, (i % 4) == 3);
            end
        end
        n_cmp++;
        if ({symbol_o, busy_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset got=%b exp=00", {symbol_o, busy_o});
        end
        repeat (20) @(negedge clock);
    endtask

    task automatic test_normal();
        int i = 0;
        logic o; bit e;
        run_burst(-1, -1, -1, -1);
        n_cmp++;
        if (obs_q.size() != NSYM) begin
            n_bad++; $display("FAIL normal_len got=%0d exp=%0d", obs_q.size(), NSYM);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL normal_sym[%0d] got=%b exp=%b", i, o, e); end
            i++;
        end
        n_cmp++; if (n_ready != FULL_READY) begin n_bad++; $display("FAIL normal_ready got=%0d exp=%0d", n_ready, FULL_READY); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL normal_done_cnt got=%0d exp=1", n_done); end
        n_cmp++; if (done_at != NSYM) begin n_bad++; $display("FAIL normal_done_at got=%0d exp=%0d", done_at, NSYM); end
        n_cmp++; if (busy_start !== 1'b1) begin n_bad++; $display("FAIL normal_busy_start got=%b exp=1", busy_start); end
        n_cmp++; if (txa_pay !== 1'b1) begin n_bad++; $display("FAIL normal_txa_pay got=%b exp=1", txa_pay); end
        n_cmp++; if ({busy_end, txa_end, und_end} !== 3'b000) begin
            n_bad++; $display("FAIL normal_end_flags got=%b exp=000", {busy_end, txa_end, und_end});
        end
    endtask

    task automatic test_underrun();
        int i = 0;
        logic o; bit e;
        run_burst(10, 12, -1, -1);
        n_cmp++;
        if (obs_q.size() != NSYM) begin
            n_bad++; $display("FAIL under_len got=%0d exp=%0d", obs_q.size(), NSYM);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL under_sym[%0d] got=%b exp=%b", i, o, e); end
            i++;
        end
        n_cmp++; if (n_ready != exp_ready) begin n_bad++; $display("FAIL under_ready got=%0d exp=%0d", n_ready, exp_ready); end
        n_cmp++; if (done_at != NSYM) begin n_bad++; $display("FAIL under_done_at got=%0d exp=%0d", done_at, NSYM); end
        n_cmp++; if (und_end !== 1'b1) begin n_bad++; $display("FAIL under_sticky got=%b exp=1", und_end); end
    endtask

    task automatic test_restart_ignored();
        int i = 0;
        logic o; bit e;
        run_burst(-1, -1, 60, -1);
        n_cmp++; if (und_start !== 1'b0) begin n_bad++; $display("FAIL restart_und_clear got=%b exp=0", und_start); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL restart_sym[%0d] got=%b exp=%b", i, o, e); end
            i++;
        end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL restart_done_cnt got=%0d exp=1", n_done); end
        n_cmp++; if (n_ready != FULL_READY) begin n_bad++; $display("FAIL restart_ready got=%0d exp=%0d", n_ready, FULL_READY); end
        n_cmp++; if (done_at != NSYM) begin n_bad++; $display("FAIL restart_done_at got=%0d exp=%0d", done_at, NSYM); end
        n_cmp++; if (busy_end !== 1'b0) begin n_bad++; $display("FAIL restart_busy_end got=%b exp=0", busy_end); end
    endtask

    task automatic test_reset_mid();
        int i = 0;
        logic o; bit e;
        run_burst(10, 12, -1, 53);
        #1;
        n_cmp++;
        if ({bit_ready_o, sample_strobe_o, symbol_o, busy_o, tx_active_o, underrun_o, done_o} !== 7'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs got=%b exp=0000000",
                     {bit_ready_o, sample_strobe_o, symbol_o, busy_o, tx_active_o, underrun_o, done_o});
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        run_burst(-1, -1, -1, -1);
        n_cmp++;
        if (obs_q.size() != NSYM) begin
            n_bad++; $display("FAIL after_reset_len got=%0d exp=%0d", obs_q.size(), NSYM);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL after_reset_sym[%0d] got=%b exp=%b", i, o, e); end
            i++;
        end
        n_cmp++; if (n_ready != FULL_READY) begin n_bad++; $display("FAIL after_reset_ready got=%0d exp=%0d", n_ready, FULL_READY); end
        n_cmp++; if (done_at != NSYM) begin n_bad++; $display("FAIL after_reset_done_at got=%0d exp=%0d", done_at, NSYM); end
    endtask

`ifdef GMSK_BURST_TSC_EN
    task automatic test_tsc();
        int i = 0;
        logic o; bit e;
        tsc_sel_i = 3'd0;
        run_burst(-1, -1, -1, -1);
        tsc_sel_i = 3'd5;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL tsc_sym[%0d] got=%b exp=%b", i, o, e); end
            i++;
        end
        n_cmp++; if (n_ready != 116) begin n_bad++; $display("FAIL tsc_ready got=%0d exp=116", n_ready); end
        tsc_sel_i = 3'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_underrun();
        test_restart_ignored();
        test_reset_mid();
`ifdef GMSK_BURST_TSC_EN
        test_tsc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
